// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/result bundle between an ALU client and multicycle_alu.
interface multicycle_alu_if;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;
    logic        done;
    logic        invalid_op;
    modport master (output start, ALUOperation, A, B, shamt,
                    input  ALUResult, Zero, busy, done, invalid_op);
    modport slave  (input  start, ALUOperation, A, B, shamt,
                    output ALUResult, Zero, busy, done, invalid_op);
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle logic/arith ops, bit-serial SLL/SRL, registered result and flags.
module multicycle_alu (
    input logic              clk,
    input logic              reset,
    multicycle_alu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] res_q, res_d, calc;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d, inv_q, inv_d, zero_q;
    logic        accept, is_shift;
    assign accept   = state_q == IDLE && bus.start;
    assign is_shift = bus.ALUOperation[3:1] == 3'b011;
    always_comb begin
        calc = 32'h0;
        case (bus.ALUOperation)
            4'd0: calc = bus.A & bus.B;
            4'd1: calc = bus.A | bus.B;
            4'd2: calc = ~(bus.A | bus.B);
            4'd3: calc = bus.A + bus.B;
            4'd4: calc = bus.A - bus.B;
            4'd5: calc = {bus.B[15:0], 16'h0000};
            4'd6, 4'd7: calc = bus.B;
            default: calc = 32'h0;
        endcase
    end
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: if (accept) begin
                res_d   = calc;
                inv_d   = bus.ALUOperation[3];
                left_d  = bus.ALUOperation == 4'd6;
                cnt_d   = is_shift ? bus.shamt : 5'd0;
                state_d = (is_shift && bus.shamt != 5'd0) ? SHIFT : DONE;
            end
            SHIFT: begin
                // one bit per cycle; the final shift lands as the FSM enters DONE
                res_d   = left_q ? res_q << 1 : res_q >> 1;
                cnt_d   = cnt_q - 5'd1;
                state_d = cnt_q == 5'd1 ? DONE : SHIFT;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= 32'h0;
            zero_q  <= 1'b1;
            cnt_q   <= 5'd0;
            left_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= res_d == 32'h0;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            inv_q   <= inv_d;
        end
    end
    assign bus.ALUResult  = res_q;
    assign bus.Zero       = zero_q;
    assign bus.invalid_op = inv_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DONE;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed scoreboard bench for multicycle_alu.
module tb_multicycle_alu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [31:0] res;
        logic        inv;
        int          lat;
    } exp_t;
    exp_t sbq[$];
    multicycle_alu_if bus ();
    multicycle_alu dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return ~(a | b);
            4'd3: return a + b;
            4'd4: return a - b;
            4'd5: return {b[15:0], 16'h0000};
            4'd6: return b << sh;
            4'd7: return b >> sh;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh, input bit disturb);
        exp_t e;
        int n;
        e.res = model(op, a, b, sh);
        e.inv = op[3];
        e.lat = (op == 4'd6 || op == 4'd7) ? int'(sh) : 0;
        sbq.push_back(e);
        @(negedge clk);
        bus.ALUOperation = op; bus.A = a; bus.B = b; bus.shamt = sh; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 100) begin
            if (disturb) begin
                chk("busy_mid", {31'b0, bus.busy}, 32'd1);
                bus.start = 1'b1;
                bus.B = $urandom;
                bus.A = $urandom;
                bus.ALUOperation = 4'(n);
                bus.shamt = 5'(n);
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("done_seen", {31'b0, bus.done}, 32'd1);
        e = sbq.pop_front();
        chk("latency", n, e.lat + 1);
        chk("result", bus.ALUResult, e.res);
        chk("zero", {31'b0, bus.Zero}, {31'b0, e.res == 32'h0});
        chk("invalid", {31'b0, bus.invalid_op}, {31'b0, e.inv});
        chk("busy_done", {31'b0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("done_pulse", {31'b0, bus.done}, 32'd0);
        chk("idle_busy", {31'b0, bus.busy}, 32'd0);
        chk("result_hold", bus.ALUResult, e.res);
    endtask

    initial begin
        bit seen;
        bus.start = 1'b0; bus.ALUOperation = 4'd0; bus.A = 32'h0; bus.B = 32'h0; bus.shamt = 5'd0;
        repeat (2) @(negedge clk);
        chk("rst_result", bus.ALUResult, 32'h0);
        chk("rst_zero", {31'b0, bus.Zero}, 32'd1);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_inv", {31'b0, bus.invalid_op}, 32'd0);
        bus.start = 1'b1; bus.ALUOperation = 4'd3; bus.A = 32'h5; bus.B = 32'h6;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_in_reset", {31'b0, bus.busy}, 32'd0);
        run(4'd3, 32'h7FFFFFFF, 32'h00000001, 5'd0, 1'b0);
        run(4'd4, 32'h12345678, 32'h12345678, 5'd0, 1'b0);
        run(4'd5, 32'h0, 32'h0000ABCD, 5'd0, 1'b0);
        run(4'd0, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd0, 1'b0);
        run(4'd1, 32'hF0F00000, 32'h0000000F, 5'd0, 1'b0);
        run(4'd2, 32'hF0F00000, 32'h0000000F, 5'd0, 1'b0);
        run(4'd6, 32'h0, 32'h00000001, 5'd31, 1'b1);
        run(4'd7, 32'h0, 32'h80000000, 5'd4, 1'b1);
        run(4'd7, 32'h0, 32'hDEADBEEF, 5'd0, 1'b1);
        run(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0);
        run(4'd0, 32'hFFFFFFFF, 32'h00000003, 5'd0, 1'b0);
        run(4'd15, 32'h1, 32'h2, 5'd3, 1'b0);
        run(4'd6, 32'h0, 32'h00000001, 5'd1, 1'b0);
        // abort a long shift with reset, then make sure no stale done escapes
        @(negedge clk);
        bus.ALUOperation = 4'd6; bus.B = 32'h00000003; bus.shamt = 5'd20; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_result", bus.ALUResult, 32'h0);
        chk("abort_zero", {31'b0, bus.Zero}, 32'd1);
        chk("abort_busy0", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_inv", {31'b0, bus.invalid_op}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen |= bus.done | bus.busy;
        end
        chk("abort_no_done", {31'b0, seen}, 32'd0);
        run(4'd3, 32'h00000010, 32'h00000020, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            run(4'($urandom_range(0, 9)), $urandom, $urandom, 5'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        chk("queue_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
